// File: rtl/data_mem_controller_if.sv
// rtl/data_mem_controller_if.sv - requester, status and memory bus bundle for data_mem_controller
// Ports (signals):
//   cpu_req/we/size/addr/wdata -> controller, cpu_ready <- controller
//   dma_req/we/size/addr/wdata -> controller, dma_ready <- controller
//   rdata, err, busy           <- controller (shared status/result)
//   mem_addr, mem_wdata, mem_we <- controller; mem_rdata -> controller (sync-read memory)
// Modports: master = requesters plus memory side, slave = controller.
interface data_mem_controller_if #(
    parameter int ADDR_W = 11
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;

    logic              dma_req;
    logic              dma_we;
    logic [1:0]        dma_size;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ready;

    logic [31:0]       rdata;
    logic              err;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_size, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ready, dma_ready, rdata, err, busy,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_size, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ready, dma_ready, rdata, err, busy,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - round-robin byte sequencer for the 2 KB big-endian data memory
// Shares a byte-wide synchronous-read memory between a CPU port and a DMA port.
// Each byte/halfword/word request becomes 1/2/4 byte cycles; one ready pulse per
// request, read data right-justified.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - data_mem_controller_if.slave (requester ports, status, memory bus)
// Optional macro DMC_UNALIGNED_EN: misaligned requests run byte-serially with
// address wrap instead of being rejected.
module data_mem_controller #(
    parameter int ADDR_W = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    data_mem_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_dma;
    logic              gnt_dma;
    logic              we_q;
    logic              err_q;
    logic [2:0]        n_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;

    logic              req_any;
    logic              sel_dma;
    logic              r_we;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_n;
    logic              r_illegal;
    logic              last_byte;
    logic [1:0]        byte_idx;

    assign req_any   = bus.cpu_req | bus.dma_req;
    assign last_byte = ({1'b0, k_q} == (n_q - 3'd1));
    // Big-endian: byte k of the transfer is byte (n-1-k) of the store data.
    assign byte_idx  = 2'(n_q - 3'd1 - {1'b0, k_q});

    // Arbitration and request field selection.
    always_comb begin
        sel_dma = bus.dma_req;
        if (bus.cpu_req && bus.dma_req)
            sel_dma = ~last_dma;
        r_we    = sel_dma ? bus.dma_we    : bus.cpu_we;
        r_size  = sel_dma ? bus.dma_size  : bus.cpu_size;
        r_addr  = sel_dma ? bus.dma_addr  : bus.cpu_addr;
        r_wdata = sel_dma ? bus.dma_wdata : bus.cpu_wdata;
        case (r_size)
            2'd1:    r_n = 3'd2;
            2'd2:    r_n = 3'd4;
            default: r_n = 3'd1;
        endcase
`ifdef DMC_UNALIGNED_EN
        r_illegal = (r_size == 2'd3);
`else
        r_illegal = (r_size == 2'd3)
                  || ((r_size == 2'd1) && r_addr[0])
                  || ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cpu_ready = 1'b0;
        bus.dma_ready = 1'b0;
        bus.err       = 1'b0;
        bus.rdata     = 32'd0;
        bus.busy      = (state != IDLE);
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'd0;
        bus.mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req_any)
                    state_nxt = r_illegal ? DONE : XFER;
            end
            XFER: begin
                bus.mem_addr = base_q + ADDR_W'(k_q);
                bus.mem_we   = we_q;
                if (we_q)
                    bus.mem_wdata = wdata_q[8*byte_idx +: 8];
                if (last_byte)
                    state_nxt = we_q ? DONE : WAIT;
            end
            WAIT: state_nxt = DONE;
            DONE: begin
                bus.cpu_ready = ~gnt_dma;
                bus.dma_ready = gnt_dma;
                bus.err       = err_q;
                bus.rdata     = acc_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dma <= 1'b1;
            gnt_dma  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            n_q      <= 3'd1;
            k_q      <= 2'd0;
            base_q   <= '0;
            wdata_q  <= 32'd0;
            acc_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_dma  <= sel_dma;
                        last_dma <= sel_dma;
                        we_q     <= r_we;
                        err_q    <= r_illegal;
                        n_q      <= r_n;
                        k_q      <= 2'd0;
                        base_q   <= r_addr;
                        wdata_q  <= r_wdata;
                        acc_q    <= 32'd0;
                    end
                end
                XFER: begin
                    k_q <= k_q + 2'd1;
                    // Read data lags the address by one cycle, so byte k-1 lands now.
                    if (!we_q && (k_q != 2'd0))
                        acc_q <= {acc_q[23:0], bus.mem_rdata};
                end
                WAIT: acc_q <= {acc_q[23:0], bus.mem_rdata};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - self-checking bench for data_mem_controller
module tb_data_mem_controller;
    localparam int AW  = 11;
    localparam int MSZ = 2048;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_mem_controller_if #(.ADDR_W(AW)) bus ();
    data_mem_controller #(.ADDR_W(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [7:0] mem     [0:MSZ-1] = '{default: 8'h00};
    logic [7:0] ref_mem [0:MSZ-1] = '{default: 8'h00};

    always @(posedge clock) begin
        if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit legal_req(input logic [1:0] size, input logic [AW-1:0] addr);
        if (size == 2'd3) return 1'b0;
`ifndef DMC_UNALIGNED_EN
        if ((int'(addr) % (1 << size)) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic run_req(input bit dma, input bit we, input logic [1:0] size,
                           input logic [AW-1:0] addr, input logic [31:0] wdata);
        int          n;
        bit          ok;
        int          exp_lat;
        int          lat;
        int          a;
        logic [31:0] exp_rd;
        logic [31:0] obs_rd;
        logic        obs_err;
        logic        own;
        logic        other;
        logic [7:0]  b;
        n       = (size == 2'd3) ? 1 : (1 << size);
        ok      = legal_req(size, addr);
        exp_lat = !ok ? 1 : (we ? n + 1 : n + 2);
        exp_rd  = 32'd0;
        if (ok && !we)
            for (int k = 0; k < n; k++)
                exp_rd = (exp_rd << 8) | 32'(ref_mem[(int'(addr) + k) % MSZ]);
        lat     = -1;
        obs_rd  = 32'hxxxxxxxx;
        obs_err = 1'bx;

        @(posedge clock);
        #1;
        if (dma) begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_size = size;
            bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = size;
            bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end

        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            own   = dma ? bus.dma_ready : bus.cpu_ready;
            other = dma ? bus.cpu_ready : bus.dma_ready;
            if (ok && c >= 1 && c <= n) begin
                a = (int'(addr) + c - 1) % MSZ;
                check("mem_we", 32'(bus.mem_we), 32'(we));
                check("mem_addr", 32'(bus.mem_addr), 32'(a));
                if (we) begin
                    b = 8'(wdata >> (8 * (n - c)));
                    check("mem_wdata", 32'(bus.mem_wdata), 32'(b));
                end
            end else begin
                check("mem_we_quiet", 32'(bus.mem_we), 32'd0);
            end
            check("busy", 32'(bus.busy), (c == 0) ? 32'd0 : 32'd1);
            check("other_ready", 32'(other), 32'd0);
            if (own === 1'b1) begin
                lat     = c;
                obs_rd  = bus.rdata;
                obs_err = bus.err;
                break;
            end
        end
        if (dma) bus.dma_req = 1'b0;
        else     bus.cpu_req = 1'b0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(obs_err), ok ? 32'd0 : 32'd1);
        check("rdata", obs_rd, exp_rd);
        if (ok && we)
            for (int k = 0; k < n; k++)
                ref_mem[(int'(addr) + k) % MSZ] = 8'(wdata >> (8 * (n - 1 - k)));
    endtask

    initial begin
        logic        order [$];
        logic [1:0]  rsize;
        logic [AW-1:0] raddr;

        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'd0;
        bus.cpu_addr = 11'h010; bus.cpu_wdata = 32'd0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_size = 2'd0;
        bus.dma_addr = 11'h020; bus.dma_wdata = 32'd0;

        #2;
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_dma_ready", 32'(bus.dma_ready), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);

        // Both requesters held from reset: grants must alternate, CPU first.
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(negedge clock);
            check("ready_overlap", 32'(bus.cpu_ready & bus.dma_ready), 32'd0);
            if (bus.cpu_ready === 1'b1) order.push_back(1'b0);
            if (bus.dma_ready === 1'b1) order.push_back(1'b1);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr_order", (order.size() > i) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));

        run_req(1'b0, 1'b1, 2'd2, 11'h010, 32'hDEADBEEF);
        run_req(1'b0, 1'b0, 2'd2, 11'h010, 32'd0);
        run_req(1'b1, 1'b1, 2'd1, 11'h020, 32'h0000_1234);
        run_req(1'b1, 1'b0, 2'd0, 11'h021, 32'd0);
        run_req(1'b0, 1'b0, 2'd2, 11'h7FE, 32'd0);
        run_req(1'b1, 1'b0, 2'd3, 11'h100, 32'd0);

        // Reset during the second byte of a word store.
        @(posedge clock);
        #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'd2;
        bus.cpu_addr = 11'h040; bus.cpu_wdata = 32'hA1B2C3D4;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.cpu_ready), 32'd0);
        bus.cpu_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("abort_no_ready", 32'(bus.cpu_ready | bus.dma_ready), 32'd0);
        end
        reset = 1'b0;
        ref_mem[11'h040] = 8'hA1;
        run_req(1'b0, 1'b0, 2'd2, 11'h040, 32'd0);

        for (int i = 0; i < 60; i++) begin
            rsize = 2'($urandom_range(0, 3));
            raddr = AW'($urandom_range(0, MSZ - 1));
            if ($urandom_range(0, 3) != 0 && rsize != 2'd3)
                raddr = raddr & ~AW'((1 << rsize) - 1);
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsize, raddr, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Sequencer and arbiter in front of the 2 KB byte-wide, big-endian data memory.
- Shares the memory between two requesters: the CPU load/store port and a DMA/loader port. Round-robin arbitration.
- Converts each byte, halfword or word request into 1, 2 or 4 byte cycles on the memory.
- Returns one ready pulse per request, with read data right-justified.

Parameters:
- ADDR_W, 11, byte address width. The memory holds 2^ADDR_W bytes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data; low 1/2/4 bytes used.
- cpu_ready  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_size, dma_addr, dma_wdata, dma_ready: same as the cpu_ signals, for the DMA port.
- rdata  out  32  load result; valid only in the cycle a ready pulses.
- err  out  1  pulses together with a ready when the request was rejected.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_we  out  1  byte write strobe.
- mem_rdata  in  8  memory read byte; valid the cycle after mem_addr is presented (synchronous read).

Behaviour:
- Reset values:
  - State goes to IDLE.
  - All outputs go to 0 immediately: cpu_ready, dma_ready, err, busy, mem_we, mem_addr, mem_wdata, rdata.
  - last_grant = DMA, so the CPU wins the first tie.
- States: IDLE, XFER, WAIT, DONE.
- IDLE:
  - If any req is high, grant one requester.
  - On a tie, grant the requester not in last_grant; then update last_grant.
  - At the grant edge, latch we, size, addr and wdata; set n = 1/2/4 and k = 0.
  - An illegal request goes directly to DONE with err = 1. Illegal means size == 3, or addr not a multiple of n.
  - A legal request goes to XFER.
- XFER, one byte per cycle for k = 0..n-1:
  - mem_addr = base + k, modulo 2^ADDR_W.
  - Stores: mem_we = 1 and mem_wdata = wdata byte (n-1-k) counted from the LSB. Big-endian: the lowest address takes the most-significant used byte.
  - Loads: mem_we = 0. From the cycle after byte 0 is issued, shift mem_rdata into the accumulator as acc = {acc[23:0], mem_rdata}.
  - After k = n-1: stores go to DONE; loads go to WAIT.
- WAIT (loads only): capture the last byte, then go to DONE.
- DONE:
  - Pulse the granted port's ready for one cycle.
  - rdata = accumulator, zero-extended; it is 0 for stores and errors.
  - err as decided at grant.
  - Next state is IDLE.
- Latency from the grant cycle T0:
  - Store: ready at T(n+1).
  - Load: ready at T(n+2).
  - Error: ready at T1.
- Requester handshake:
  - A requester drops req at its ready pulse at the latest.
  - If req is still high in the following IDLE cycle, it is treated as a new request.
  - Changes to fields after the grant are ignored.
- The non-granted requester simply waits; its req stays pending and no ready is issued to it.
- Exactly one ready is issued per granted request. cpu_ready and dma_ready are never high in the same cycle.
- Reset mid-transfer:
  - Abort at once; no ready is issued.
  - Bytes already written stay in memory (no rollback). The requester must reissue.

Optional Feature:
- Macro DMC_UNALIGNED_EN.
- Defined: misaligned byte/halfword/word requests are legal. They run byte-serially with the same timing, and addresses wrap modulo 2^ADDR_W (e.g. a word at 0x7FE touches 0x7FE, 0x7FF, 0x000, 0x001). Only size == 3 sets err.
- Undefined: misaligned requests set err, take no memory cycles, and complete with ready at T1.

Test Plan:
- CPU store word at 0x010 with wdata 0xDEADBEEF -> mem writes DE@0x010, AD@0x011, BE@0x012, EF@0x013 on T1..T4; cpu_ready at T5, err = 0.
- CPU load word at 0x010 after that store -> cpu_ready at T6 with rdata = 0xDEADBEEF.
- DMA store halfword 0x1234 at 0x020, then DMA load byte at 0x021 -> rdata = 0x00000034.
- cpu_req and dma_req both raised from reset, both held for repeated requests -> grants CPU, DMA, CPU, DMA; ready pulses never overlap.
- CPU load word at 0x7FE:
  - Without the macro: err = 1, cpu_ready at T1, mem_we never high.
  - With DMC_UNALIGNED_EN: bytes are read from 0x7FE, 0x7FF, 0x000, 0x001.
- Reset asserted in T2 of a word store -> mem_we low at once; no ready; busy = 0; memory holds only the byte written in T1.
